// File: rtl/wbm_timeout_bridge_pkg.sv
// rtl/wbm_timeout_bridge_pkg.sv - shared types and constants for the Wishbone timeout bridge
//
// Purpose : FSM state encoding and timeout-counter sizing shared by the bridge.
// Contents: state_t      - bridge FSM states
//           TIMEOUT_DEFAULT - default abort limit in cycles
//           cnt_width()  - counter width able to hold the timeout limit itself
package wbm_timeout_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam int TIMEOUT_DEFAULT = 255;

   // The counter must be able to represent TIMEOUT_CYCLES, hence the +1.
   function automatic int cnt_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/wbm_timeout_bridge.sv
// rtl/wbm_timeout_bridge.sv - single-outstanding Wishbone bridge with downstream timeout abort
//
// Purpose : Forwards one upstream Wishbone transaction at a time to a pipelined
//           downstream Wishbone slave, aborting with an error if no ack/err
//           arrives within TIMEOUT_CYCLES, and counting errors.
// Ports   : clk, rst_n                       - clock, async active-low reset
//           s_adr/s_dat_w/s_sel/s_we/s_stb/s_cyc -> upstream request
//           s_dat_r/s_ack/s_err/s_stall      <- upstream response / flow control
//           m_adr/m_dat_w/m_sel/m_we/m_stb/m_cyc <- downstream request
//           m_dat_r/m_ack/m_err/m_stall      -> downstream response / stall
//           err_cnt_clr -> / err_cnt <-      - saturating error+timeout count
//           timeout_pulse                    <- one cycle per timeout abort
module wbm_timeout_bridge
   import wbm_timeout_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] s_adr,
   input  logic [31:0] s_dat_w,
   output logic [31:0] s_dat_r,
   input  logic [3:0]  s_sel,
   input  logic        s_we,
   input  logic        s_stb,
   input  logic        s_cyc,
   output logic        s_ack,
   output logic        s_err,
   output logic        s_stall,
   output logic [29:0] m_adr,
   output logic [31:0] m_dat_w,
   output logic [3:0]  m_sel,
   output logic        m_we,
   output logic        m_stb,
   output logic        m_cyc,
   input  logic [31:0] m_dat_r,
   input  logic        m_ack,
   input  logic        m_err,
   input  logic        m_stall,
   input  logic        err_cnt_clr,
   output logic [7:0]  err_cnt,
   output logic        timeout_pulse
);

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [29:0]      r_m_adr;
   logic [31:0]      r_m_dat_w;
   logic [3:0]       r_m_sel;
   logic             r_m_we, r_m_stb, r_m_cyc;
   logic [31:0]      r_s_dat_r;
   logic             r_s_ack, r_s_err, r_to_pulse;
   logic [7:0]       r_err_cnt;

   logic w_capture, w_accept, w_drop, w_go_ack, w_go_err, w_to_hit, w_to_due;

   // Counter holds k-1 during the k-th cycle of REQ/WAIT, so the abort edge
   // ends the TIMEOUT_CYCLES-th cycle with m_cyc high.
   assign w_to_due = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      w_drop      = 1'b0;
      w_go_ack    = 1'b0;
      w_go_err    = 1'b0;
      w_to_hit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (s_cyc && s_stb) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            // Upstream abandon beats everything; a real response beats a
            // timeout landing on the same edge.
            if (!s_cyc) begin
               w_drop      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (!m_stall && (m_ack || m_err)) begin
               w_go_err    = m_err;
               w_go_ack    = !m_err;
               w_state_nxt = ST_RESP;
            end else if (w_to_due) begin
               w_to_hit    = 1'b1;
               w_go_err    = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (!m_stall) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!s_cyc) begin
               w_drop      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (m_ack || m_err) begin
               w_go_err    = m_err;
               w_go_ack    = !m_err;
               w_state_nxt = ST_RESP;
            end else if (w_to_due) begin
               w_to_hit    = 1'b1;
               w_go_err    = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_m_adr    <= '0;
         r_m_dat_w  <= '0;
         r_m_sel    <= '0;
         r_m_we     <= 1'b0;
         r_m_stb    <= 1'b0;
         r_m_cyc    <= 1'b0;
         r_s_dat_r  <= '0;
         r_s_ack    <= 1'b0;
         r_s_err    <= 1'b0;
         r_to_pulse <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         // Response flags live only for the single RESP cycle.
         r_s_ack    <= w_go_ack;
         r_s_err    <= w_go_err;
         r_to_pulse <= w_to_hit;

         if (w_capture) begin
            r_m_adr   <= s_adr;
            r_m_dat_w <= s_dat_w;
            r_m_sel   <= s_sel;
            r_m_we    <= s_we;
            r_m_cyc   <= 1'b1;
            r_m_stb   <= 1'b1;
            r_cnt     <= '0;
         end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_accept) r_m_stb <= 1'b0;

         if (w_go_ack || w_go_err || w_drop) begin
            r_m_cyc <= 1'b0;
            r_m_stb <= 1'b0;
         end

         if (w_go_ack) r_s_dat_r <= m_dat_r;

         if (err_cnt_clr)                          r_err_cnt <= '0;
         else if (w_go_err && r_err_cnt != 8'hFF)  r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign m_adr         = r_m_adr;
   assign m_dat_w       = r_m_dat_w;
   assign m_sel         = r_m_sel;
   assign m_we          = r_m_we;
   assign m_stb         = r_m_stb;
   assign m_cyc         = r_m_cyc;
   assign s_dat_r       = r_s_dat_r;
   assign s_ack         = r_s_ack & s_cyc;
   assign s_err         = r_s_err & s_cyc;
   assign s_stall       = (r_state != ST_IDLE);
   assign err_cnt       = r_err_cnt;
   assign timeout_pulse = r_to_pulse;

endmodule

// File: tb/tb_wbm_timeout_bridge.sv
// tb/tb_wbm_timeout_bridge.sv - self-checking bench for wbm_timeout_bridge
module tb_wbm_timeout_bridge;

   localparam int T = 8;
   localparam int L = T + 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [29:0] s_adr;
   logic [31:0] s_dat_w, s_dat_r;
   logic [3:0]  s_sel;
   logic        s_we, s_stb, s_cyc, s_ack, s_err, s_stall;
   logic [29:0] m_adr;
   logic [31:0] m_dat_w, m_dat_r;
   logic [3:0]  m_sel;
   logic        m_we, m_stb, m_cyc, m_ack, m_err, m_stall;
   logic        err_cnt_clr;
   logic [7:0]  err_cnt;
   logic        timeout_pulse;

   wbm_timeout_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_sel(s_sel),
      .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
      .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
      .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we),
      .m_stb(m_stb), .m_cyc(m_cyc),
      .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
      .err_cnt_clr(err_cnt_clr), .err_cnt(err_cnt), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // observations of the last transaction
   int ob_ack, ob_err, ob_pulse, ob_resp, ob_mcyc, ob_stb, ob_acc, ob_stall;
   bit ob_stable;
   logic [31:0] ob_dat;

   // reference state
   int          em;
   logic [31:0] last_dat;

   typedef struct {
      logic [29:0] adr; logic [31:0] wd; logic [3:0] sel; logic we;
      int n_stall; int d; bit is_err; logic [31:0] rd;
      int exp_ack; int exp_err; int exp_pulse; int exp_resp; int exp_stb; int exp_acc;
      logic [31:0] exp_dat; int exp_cnt;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One upstream transaction; the downstream responder stalls the first
   // n_stall cycles and answers in cycle n_stall+1+d (counted from capture).
   task automatic run_txn(input logic [29:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                          input logic we, input int n_stall, input int d, input bit is_err,
                          input logic [31:0] rd, input int drop_cyc, input int clr_cyc);
      ob_ack = 0; ob_err = 0; ob_pulse = 0; ob_resp = 0; ob_mcyc = 0;
      ob_stb = 0; ob_acc = 0; ob_stall = 0; ob_stable = 1; ob_dat = 'x;
      @(negedge clk);
      s_adr = adr; s_dat_w = wd; s_sel = sel; s_we = we; s_cyc = 1'b1; s_stb = 1'b1;
      for (int j = 1; j <= L; j++) begin
         @(negedge clk);
         s_stb = 1'b0;
         if (s_ack) begin ob_ack++; ob_resp = j; ob_dat = s_dat_r; end
         if (s_err) begin ob_err++; ob_resp = j; end
         if (timeout_pulse) ob_pulse++;
         if (m_cyc) ob_mcyc++;
         if (s_stall) ob_stall++;
         m_stall = (j <= n_stall);
         m_ack = 1'b0; m_err = 1'b0;
         if (j == n_stall + 1 + d) begin
            m_ack = !is_err; m_err = is_err; m_dat_r = rd;
         end
         if (m_stb) begin
            ob_stb++;
            if (m_adr !== adr || m_dat_w !== wd || m_sel !== sel || m_we !== we) ob_stable = 0;
            if (!m_stall) ob_acc++;
         end
         err_cnt_clr = (j == clr_cyc);
         if (j == drop_cyc) s_cyc = 1'b0;
      end
      @(negedge clk);
      s_cyc = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_stall = 1'b0; err_cnt_clr = 1'b0;
   endtask

   task automatic check_obs(input string tag, input int e_ack, input int e_err, input int e_pulse,
                            input int e_resp, input int e_stb, input int e_acc,
                            input logic [31:0] e_dat, input int e_cnt);
      chk({tag, ".ack"},    ob_ack,    e_ack);
      chk({tag, ".err"},    ob_err,    e_err);
      chk({tag, ".pulse"},  ob_pulse,  e_pulse);
      chk({tag, ".rcyc"},   ob_resp,   e_resp);
      chk({tag, ".mcyc"},   ob_mcyc,   e_resp - 1);
      chk({tag, ".stall"},  ob_stall,  e_resp);
      chk({tag, ".stb"},    ob_stb,    e_stb);
      chk({tag, ".acc"},    ob_acc,    e_acc);
      chk({tag, ".stable"}, ob_stable, 1);
      chk({tag, ".dat"},    s_dat_r,   e_dat);
      chk({tag, ".cnt"},    err_cnt,   e_cnt);
   endtask

   // Reference outcome from the rules: a response in cycle r wins if r <= T,
   // otherwise the bridge aborts at the end of cycle T.
   task automatic model_check(input string tag, input int n_stall, input int d,
                              input bit is_err, input logic [31:0] rd);
      int r, e_ack, e_err, e_pulse, e_resp, e_stb, e_acc;
      r = n_stall + 1 + d;
      if (r <= T) begin
         e_ack = is_err ? 0 : 1; e_err = is_err ? 1 : 0; e_pulse = 0; e_resp = r + 1;
      end else begin
         e_ack = 0; e_err = 1; e_pulse = 1; e_resp = T + 1;
      end
      e_stb = (n_stall + 1 < T) ? n_stall + 1 : T;
      e_acc = (n_stall + 1 <= T) ? 1 : 0;
      if (e_ack == 1) last_dat = rd;
      if (e_err == 1 && em < 255) em++;
      check_obs(tag, e_ack, e_err, e_pulse, e_resp, e_stb, e_acc, last_dat, em);
   endtask

   initial begin
      logic [29:0] ra; logic [31:0] rw, rr; logic [3:0] rs; logic rwe; int ns, dd; bit ie;

      tbl[0] = '{30'h10,       32'h0,         4'hF,    1'b0, 0,  3, 0, 32'hDEADBEEF, 1, 0, 0, 5, 1, 1, 32'hDEADBEEF, 0};
      tbl[1] = '{30'h400,      32'hA5A50F0F,  4'b0011, 1'b1, 4,  2, 0, 32'h11112222, 1, 0, 0, 8, 5, 1, 32'h11112222, 0};
      tbl[2] = '{30'h123,      32'h0,         4'hF,    1'b0, 0, 99, 0, 32'h33333333, 0, 1, 1, 9, 1, 1, 32'h11112222, 1};
      tbl[3] = '{30'h2AA,      32'h0,         4'hF,    1'b0, 1,  1, 1, 32'h44444444, 0, 1, 0, 4, 2, 1, 32'h11112222, 2};
      tbl[4] = '{30'h3FFFFFFF, 32'hFFFFFFFF,  4'b1000, 1'b1, 2,  0, 0, 32'h55555555, 1, 0, 0, 4, 3, 1, 32'h55555555, 2};
      tbl[5] = '{30'h55,       32'h0,         4'hF,    1'b0, 3,  4, 0, 32'h66666666, 1, 0, 0, 9, 4, 1, 32'h66666666, 2};
      tbl[6] = '{30'h66,       32'h0,         4'hF,    1'b0, 3,  5, 0, 32'h77777777, 0, 1, 1, 9, 4, 1, 32'h66666666, 3};
      tbl[7] = '{30'h77,       32'h0,         4'hF,    1'b0, 10, 0, 0, 32'h88888888, 0, 1, 1, 9, 8, 0, 32'h66666666, 4};

      rst_n = 1'b0; s_adr = '0; s_dat_w = '0; s_sel = '0; s_we = 1'b0; s_stb = 1'b0; s_cyc = 1'b0;
      m_dat_r = '0; m_ack = 1'b0; m_err = 1'b0; m_stall = 1'b0; err_cnt_clr = 1'b0;

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst.m_cyc", m_cyc, 0);   chk("rst.m_stb", m_stb, 0);   chk("rst.m_adr", m_adr, 0);
      chk("rst.s_ack", s_ack, 0);   chk("rst.s_err", s_err, 0);   chk("rst.s_stall", s_stall, 0);
      chk("rst.s_dat_r", s_dat_r, 0); chk("rst.err_cnt", err_cnt, 0); chk("rst.pulse", timeout_pulse, 0);
      rst_n = 1'b1;

      // responses arriving in IDLE are ignored
      s_cyc = 1'b1; m_ack = 1'b1; m_err = 1'b1; m_dat_r = 32'hCAFECAFE;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("idle.s_ack", s_ack, 0); chk("idle.s_err", s_err, 0); chk("idle.s_stall", s_stall, 0);
      end
      s_cyc = 1'b0; m_ack = 1'b0; m_err = 1'b0;
      @(negedge clk);
      chk("idle.err_cnt", err_cnt, 0); chk("idle.s_dat_r", s_dat_r, 0); chk("idle.m_cyc", m_cyc, 0);

      // directed table
      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].adr, tbl[i].wd, tbl[i].sel, tbl[i].we, tbl[i].n_stall, tbl[i].d,
                 tbl[i].is_err, tbl[i].rd, -1, -1);
         check_obs($sformatf("tbl%0d", i), tbl[i].exp_ack, tbl[i].exp_err, tbl[i].exp_pulse,
                   tbl[i].exp_resp, tbl[i].exp_stb, tbl[i].exp_acc, tbl[i].exp_dat, tbl[i].exp_cnt);
      end
      em = 4; last_dat = 32'h66666666;

      // randomized transactions against the reference
      for (int i = 0; i < 40; i++) begin
         ra = 30'($urandom); rw = $urandom; rr = $urandom; rs = 4'($urandom); rwe = 1'($urandom);
         ns = int'($urandom_range(0, 9)); dd = int'($urandom_range(0, 9)); ie = ($urandom_range(0, 3) == 0);
         run_txn(ra, rw, rs, rwe, ns, dd, ie, rr, -1, -1);
         model_check($sformatf("rnd%0d", i), ns, dd, ie, rr);
      end

      // upstream abandons in WAIT, late ack must not surface
      run_txn(30'h1A, 32'h0, 4'hF, 1'b0, 0, 5, 0, 32'hBAD0BAD0, 3, -1);
      chk("drop.ack", ob_ack, 0); chk("drop.err", ob_err, 0); chk("drop.pulse", ob_pulse, 0);
      chk("drop.mcyc", ob_mcyc, 3); chk("drop.stall", ob_stall, 3);
      chk("drop.dat", s_dat_r, last_dat); chk("drop.cnt", err_cnt, em);
      run_txn(30'h1B, 32'h0, 4'hF, 1'b0, 1, 2, 0, 32'h0BADF00D, -1, -1);
      model_check("after_drop", 1, 2, 0, 32'h0BADF00D);

      // reset pulsed while waiting for a response
      @(negedge clk);
      s_adr = 30'h2B; s_sel = 4'hF; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
      @(negedge clk); s_stb = 1'b0;
      @(negedge clk);
      chk("wait.m_cyc", m_cyc, 1);
      rst_n = 1'b0; #1;
      chk("arst.m_cyc", m_cyc, 0); chk("arst.m_stb", m_stb, 0); chk("arst.s_ack", s_ack, 0);
      chk("arst.s_err", s_err, 0); chk("arst.err_cnt", err_cnt, 0); chk("arst.s_dat_r", s_dat_r, 0);
      chk("arst.m_adr", m_adr, 0); chk("arst.s_stall", s_stall, 0);
      @(negedge clk); rst_n = 1'b1; s_cyc = 1'b0;
      em = 0; last_dat = 32'h0;
      run_txn(30'h2C, 32'h12345678, 4'hF, 1'b1, 2, 1, 0, 32'h0C0FFEE0, -1, -1);
      model_check("after_rst", 2, 1, 0, 32'h0C0FFEE0);

      // saturation, then clear colliding with an error
      for (int i = 0; i < 300; i++) run_txn(30'h3, 32'h0, 4'hF, 1'b0, 0, 0, 1, 32'h0, -1, -1);
      chk("sat.err_cnt", err_cnt, 255);
      run_txn(30'h4, 32'h0, 4'hF, 1'b0, 0, 0, 1, 32'h0, -1, 1);
      chk("clr.err", ob_err, 1); chk("clr.ack", ob_ack, 0); chk("clr.err_cnt", err_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
